// File: rtl/fb_port_arbiter_pkg.sv
// Shared framebuffer widths, word type and the RAM grant encoding.
package fb_port_arbiter_pkg;

  localparam int unsigned FB_ADDR_W = 14;
  localparam int unsigned FB_DATA_W = 36;

  typedef logic [FB_DATA_W-1:0] fbWord_t;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } fb_gnt_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Display-read, capture-write and RAM-side signals of the framebuffer port arbiter.
// The stall_cnt/max_level statistics exist only when FB_ARB_STATS_EN is defined.
interface fb_port_arbiter_if
  import fb_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned DATA_W      = FB_DATA_W,
  parameter int unsigned WFIFO_DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(WFIFO_DEPTH) + 1;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              vblank;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
`ifdef FB_ARB_STATS_EN
  logic [15:0]       stall_cnt;
  logic [LVL_W-1:0]  max_level;
`endif

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, vblank, ram_rdata,
    output rd_data, rd_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
           fifo_level, overflow
`ifdef FB_ARB_STATS_EN
    , output stall_cnt, max_level
`endif
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, vblank, ram_rdata,
    input  rd_data, rd_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
           fifo_level, overflow
`ifdef FB_ARB_STATS_EN
    , input stall_cnt, max_level
`endif
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of {addr,data} write entries; DEPTH must be a power of two.
module fb_wr_fifo #(
  parameter int unsigned AW    = 14,
  parameter int unsigned DW    = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [AW-1:0]              addr_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       pop_i,
  output logic [AW-1:0]              addr_o,
  output logic [DW-1:0]              data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign {addr_o, data_o} = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= {addr_i, data_i};
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, capture writes are queued
// and retired in idle RAM cycles. FB_ARB_STATS_EN adds stall_cnt/max_level statistics.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned DATA_W      = FB_DATA_W,
  parameter int unsigned WFIFO_DEPTH = 8,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic               pxlClk,
  input  logic               rst_n,
  fb_port_arbiter_if.slave   bus
);
  localparam int unsigned LVL_W = $clog2(WFIFO_DEPTH) + 1;

  fb_gnt_e           gnt;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [LVL_W-1:0]  fifo_level;

  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              vblank_q, vblank_rise;
  logic              overflow_q, overflow_d;

  always_comb begin
    gnt = GNT_IDLE;
    if (bus.rd_req)       gnt = GNT_READ;
    else if (!fifo_empty) gnt = GNT_WRITE;
  end

  assign fifo_pop     = (gnt == GNT_WRITE);
  // A pop in the same cycle frees the slot the offered entry needs.
  assign bus.wr_ready = !fifo_full || fifo_pop;
  assign fifo_push    = bus.wr_valid && bus.wr_ready;

  fb_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (pxlClk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .addr_i  (bus.wr_addr),
    .data_i  (bus.wr_data),
    .pop_i   (fifo_pop),
    .addr_o  (head_addr),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    case (gnt)
      GNT_READ: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.rd_addr;
      end
      GNT_WRITE: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = head_addr;
        bus.ram_wdata = head_data;
      end
      default: ;
    endcase
  end

  // rd_pipe_q[RD_LAT-1] marks the cycle ram_rdata carries a requested word.
  always_comb begin
    rd_pipe_d[0] = bus.rd_req;
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe_d[i] = rd_pipe_q[i-1];
    rd_valid_d = rd_pipe_q[RD_LAT-1];
    rd_data_d  = rd_pipe_q[RD_LAT-1] ? bus.ram_rdata : rd_data_q;
  end

  assign vblank_rise = bus.vblank && !vblank_q;
  assign overflow_d  = overflow_q || (vblank_rise && fifo_full && bus.wr_valid);

  always_ff @(posedge pxlClk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      vblank_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      vblank_q   <= bus.vblank;
      overflow_q <= overflow_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = overflow_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [LVL_W-1:0] max_level_q, max_level_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    max_level_d = max_level_q;
    if (vblank_rise) begin
      stall_cnt_d = '0;
      max_level_d = fifo_level;
    end else begin
      if (bus.wr_valid && !bus.wr_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (fifo_level > max_level_q) max_level_d = fifo_level;
    end
  end

  always_ff @(posedge pxlClk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      max_level_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      max_level_q <= max_level_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.max_level = max_level_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural 1-cycle-latency framebuffer RAM.
module tb_fb_port_arbiter;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 36;

  logic clk;
  logic rst_n;
  logic mem_clr;
  int   n_checks;
  int   n_errors;

  logic [DW-1:0] mem [2**AW];

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(8)) bus ();

  fb_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WFIFO_DEPTH (8),
    .RD_LAT      (1)
  ) dut (
    .pxlClk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      mem[5] <= 36'h123456789;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] fill_dat(input int i);
    return 36'hABC000000 | 36'(i);
  endfunction

  function automatic logic [DW-1:0] ovf_dat(input int i);
    return 36'hBEE000000 | 36'(i);
  endfunction

  initial begin
    int idx;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    mem_clr  = 1'b1;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.vblank   = 1'b0;
    bus.ram_rdata = '0;
    repeat (3) tick();
    mid();
    check_eq("rst_rd_data", 64'(bus.rd_data), 64'h0);
    check_eq("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    check_eq("rst_ram_en", 64'(bus.ram_en), 64'h0);
    check_eq("rst_ram_addr", 64'(bus.ram_addr), 64'h0);
    check_eq("rst_fifo_level", 64'(bus.fifo_level), 64'h0);
    check_eq("rst_overflow", 64'(bus.overflow), 64'h0);
    tick();
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    // Idle after reset
    repeat (10) tick();
    mid();
    check_eq("idle_ram_en", 64'(bus.ram_en), 64'h0);
    check_eq("idle_ram_we", 64'(bus.ram_we), 64'h0);
    check_eq("idle_wr_ready", 64'(bus.wr_ready), 64'h1);
    check_eq("idle_fifo_level", 64'(bus.fifo_level), 64'h0);
    check_eq("idle_rd_valid", 64'(bus.rd_valid), 64'h0);

    // Read latency: request at t, data at t+2
    tick();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 14'h0005;
    mid();
    check_eq("rd_ram_en", 64'(bus.ram_en), 64'h1);
    check_eq("rd_ram_we", 64'(bus.ram_we), 64'h0);
    check_eq("rd_ram_addr", 64'(bus.ram_addr), 64'h5);
    tick();
    bus.rd_req = 1'b0;
    mid();
    check_eq("rd_valid_t1", 64'(bus.rd_valid), 64'h0);
    tick();
    mid();
    check_eq("rd_valid_t2", 64'(bus.rd_valid), 64'h1);
    check_eq("rd_data_t2", 64'(bus.rd_data), 64'h123456789);
    tick();
    mid();
    check_eq("rd_valid_t3", 64'(bus.rd_valid), 64'h0);
    check_eq("rd_data_hold", 64'(bus.rd_data), 64'h123456789);

    // Fill the FIFO under continuous reads, then drain in order
    tick();
    bus.rd_req  = 1'b1;
    bus.rd_addr = '0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 14'h0100 + 14'(i);
      bus.wr_data  = fill_dat(i);
      mid();
      check_eq($sformatf("fill_rdy%0d", i), 64'(bus.wr_ready), 64'h1);
      check_eq($sformatf("fill_we%0d", i), 64'(bus.ram_we), 64'h0);
      tick();
    end
    idx = 8;
    bus.wr_addr = 14'h0108;
    bus.wr_data = fill_dat(8);
    mid();
    check_eq("full_level", 64'(bus.fifo_level), 64'h8);
    check_eq("full_wr_ready", 64'(bus.wr_ready), 64'h0);
    tick();
    mid();
    check_eq("full_hold_level", 64'(bus.fifo_level), 64'h8);
    check_eq("full_hold_we", 64'(bus.ram_we), 64'h0);
    tick();
    bus.rd_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      mid();
      check_eq($sformatf("drain_we%0d", k), 64'(bus.ram_we), 64'h1);
      check_eq($sformatf("drain_addr%0d", k), 64'(bus.ram_addr), 64'(14'h0100 + 14'(k)));
      check_eq($sformatf("drain_data%0d", k), 64'(bus.ram_wdata), 64'(fill_dat(k)));
      if (k < 2) check_eq($sformatf("bypass_rdy%0d", k), 64'(bus.wr_ready), 64'h1);
      if (k < 2) check_eq($sformatf("bypass_lvl%0d", k), 64'(bus.fifo_level), 64'h8);
      tick();
      if (bus.wr_valid) begin
        idx++;
        if (idx < 10) begin
          bus.wr_addr = 14'h0100 + 14'(idx);
          bus.wr_data = fill_dat(idx);
        end else begin
          bus.wr_valid = 1'b0;
        end
      end
    end
    mid();
    check_eq("drained_level", 64'(bus.fifo_level), 64'h0);
    check_eq("drained_ram_en", 64'(bus.ram_en), 64'h0);
    check_eq("drained_ram_we", 64'(bus.ram_we), 64'h0);

    // Collision: read of a queued address sees old RAM content
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 14'h0040;
    bus.wr_data  = 36'hAAA;
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 14'h0040;
    mid();
    check_eq("col_read_wins", 64'(bus.ram_we), 64'h0);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    mid();
    check_eq("col_retire_we", 64'(bus.ram_we), 64'h1);
    check_eq("col_retire_addr", 64'(bus.ram_addr), 64'h40);
    check_eq("col_level", 64'(bus.fifo_level), 64'h1);
    tick();
    mid();
    check_eq("col_old_valid", 64'(bus.rd_valid), 64'h1);
    check_eq("col_old_data", 64'(bus.rd_data), 64'h0);
    tick();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    mid();
    check_eq("col_new_valid", 64'(bus.rd_valid), 64'h1);
    check_eq("col_new_data", 64'(bus.rd_data), 64'hAAA);

    // Overflow: FIFO full with a held offer when vblank rises
    tick();
    bus.rd_req  = 1'b1;
    bus.rd_addr = '0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 14'h0200 + 14'(i);
      bus.wr_data  = ovf_dat(i);
      tick();
    end
    bus.wr_addr = 14'h0208;
    bus.wr_data = ovf_dat(8);
    mid();
    check_eq("ovf_before", 64'(bus.overflow), 64'h0);
    tick();
    bus.vblank = 1'b1;
    mid();
    check_eq("ovf_not_yet", 64'(bus.overflow), 64'h0);
    tick();
    mid();
    check_eq("ovf_set", 64'(bus.overflow), 64'h1);
`ifdef FB_ARB_STATS_EN
    check_eq("stats_max_level", 64'(bus.max_level), 64'h8);
    check_eq("stats_stall_clr", 64'(bus.stall_cnt), 64'h0);
`endif
    tick();
    bus.wr_valid = 1'b0;
    bus.vblank   = 1'b0;
    bus.rd_req   = 1'b0;
    repeat (3) tick();
    bus.rd_req = 1'b1;
    mid();
    check_eq("burst_level", 64'(bus.fifo_level), 64'h5);
    check_eq("ovf_sticky", 64'(bus.overflow), 64'h1);

    // Reset mid-burst drops the 5 pending writes
    tick();
    rst_n      = 1'b0;
    bus.rd_req = 1'b0;
    mid();
    check_eq("mrst_level", 64'(bus.fifo_level), 64'h0);
    check_eq("mrst_overflow", 64'(bus.overflow), 64'h0);
    check_eq("mrst_ram_en", 64'(bus.ram_en), 64'h0);
    check_eq("mrst_rd_valid", 64'(bus.rd_valid), 64'h0);
    check_eq("mrst_rd_data", 64'(bus.rd_data), 64'h0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    mid();
    check_eq("post_wr_ready", 64'(bus.wr_ready), 64'h1);
    check_eq("post_ram_en", 64'(bus.ram_en), 64'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("retired_mem%0d", i), 64'(mem[14'h0200 + 14'(i)]), 64'(ovf_dat(i)));
    end
    for (int i = 3; i < 8; i++) begin
      check_eq($sformatf("dropped_mem%0d", i), 64'(mem[14'h0200 + 14'(i)]), 64'h0);
    end
    check_eq("mem_fill_last", 64'(mem[14'h0109]), 64'(fill_dat(9)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
